// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider with start/ready handshake and annul
module div_unit #(
  parameter int WIDTH = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, abs1, abs2, q_fix, r_fix;
  logic [WIDTH:0] shifted, diff;
  logic sgn, neg_q, neg_r;
  assign sgn = SIGNED_EN && signed_div_i;
  assign abs1 = (sgn && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (sgn && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  // trial subtract: a clear sign bit means the divisor fits and the difference is kept
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff = shifted - {1'b0, dvs};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      result_o <= '0;
      ready_o <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            neg_q <= sgn && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r <= sgn && opdata1_i[WIDTH-1];
            quo <= abs1;
            dvs <= abs2;
            rem <= '0;
            cnt <= '0;
            state <= (opdata2_i == '0) ? BY_ZERO : ON;
          end
        end
        BY_ZERO: begin
          state <= END;
          result_o <= '0;
          ready_o <= 1'b1;
        end
        ON: begin
          if (annul_i) begin
            state <= IDLE;
            ready_o <= 1'b0;
            result_o <= '0;
          end else if (cnt == CW'(WIDTH)) begin
            state <= END;
            result_o <= {r_fix, q_fix};
            ready_o <= 1'b1;
          end else begin
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            state <= IDLE;
            ready_o <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit (W=32 signed, W=8 signed, W=8 unsigned-only)
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] st = '0, an = '0, sg = '0, rdy, bsy;
  logic [31:0] op1 [3];
  logic [31:0] op2 [3];
  logic [63:0] res [3];
  logic [63:0] r32;
  logic [15:0] r8a, r8b;
  logic [63:0] exp_q [3][$];
  logic [2:0] rdy_q = '0;
  bit mon_en = 1'b0;
  int passed = 0, total = 0;

  div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sg[0]), .opdata1_i(op1[0]), .opdata2_i(op2[0]),
    .start_i(st[0]), .annul_i(an[0]), .result_o(r32), .ready_o(rdy[0]), .busy_o(bsy[0]));
  div_unit #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8s (
    .clk(clk), .rst(rst), .signed_div_i(sg[1]), .opdata1_i(op1[1][7:0]), .opdata2_i(op2[1][7:0]),
    .start_i(st[1]), .annul_i(an[1]), .result_o(r8a), .ready_o(rdy[1]), .busy_o(bsy[1]));
  div_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8u (
    .clk(clk), .rst(rst), .signed_div_i(sg[2]), .opdata1_i(op1[2][7:0]), .opdata2_i(op2[2][7:0]),
    .start_i(st[2]), .annul_i(an[2]), .result_o(r8b), .ready_o(rdy[2]), .busy_o(bsy[2]));

  assign res[0] = r32;
  assign res[1] = {24'b0, r8a[15:8], 24'b0, r8a[7:0]};
  assign res[2] = {24'b0, r8b[15:8], 24'b0, r8b[7:0]};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] ex);
    total++;
    if (act === ex) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, ex);
  endtask

  // plain integer arithmetic: truncating quotient, remainder follows dividend sign
  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s, int w);
    longint m = (longint'(1) << w) - 1;
    longint sa = longint'(a) & m;
    longint sb = longint'(b) & m;
    longint q, r;
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0] & m[31:0], q[31:0] & m[31:0]};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (rdy[k] && !rdy_q[k]) begin
          if (exp_q[k].size() == 0) begin
            total++;
            $display("FAIL spurious_ready dut%0d: got result %h expected no result", k, res[k]);
          end else chk($sformatf("result dut%0d", k), res[k], exp_q[k].pop_front());
        end else if (!rdy[k]) chk($sformatf("idle_result_zero dut%0d", k), res[k], 64'd0);
      end
    end
    rdy_q = rdy;
  end

  task automatic run(int k, logic [31:0] a, logic [31:0] b, logic s, int cancel_at, bit use_rst, bit rst_end);
    int w = (k == 0) ? 32 : 8;
    int got = -1;
    logic [31:0] bm = (k == 0) ? b : (b & 32'hFF);
    op1[k] = a;
    op2[k] = b;
    sg[k] = s;
    st[k] = 1'b1;
    if (cancel_at < 0) exp_q[k].push_back(model(a, b, s && k != 2, w));
    @(posedge clk);
    @(negedge clk);
    op1[k] = $urandom;
    op2[k] = $urandom;
    sg[k] = 1'($urandom);
    for (int n = 1; n <= w + 4; n++) begin
      if (n == cancel_at) begin
        st[k] = 1'b0;
        if (use_rst) rst = 1'b0;
        else an[k] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (n == cancel_at) begin
        an[k] = 1'b0;
        rst = 1'b1;
        chk($sformatf("cancel_outputs dut%0d", k), {62'b0, rdy[k], bsy[k]}, 64'd0);
        return;
      end
      if (rdy[k]) begin
        got = n;
        break;
      end
    end
    chk($sformatf("latency dut%0d", k), 64'(got), (bm == 0) ? 64'd1 : 64'(w + 1));
    repeat ($urandom_range(1, 3)) begin
      an[k] = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("end_hold dut%0d", k), {62'b0, rdy[k], bsy[k]}, 64'd3);
    end
    an[k] = 1'b0;
    st[k] = 1'b0;
    if (rst_end) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk($sformatf("return_idle dut%0d", k), {62'b0, rdy[k], bsy[k]}, 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      op1[k] = '0;
      op2[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_flags", {58'b0, rdy, bsy}, 64'd0);
    chk("reset_result32", res[0], 64'd0);
    chk("reset_result8", res[1] | res[2], 64'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    run(0, 32'd100, 32'd7, 1'b0, -1, 0, 0);
    run(0, -32'sd7, 32'd2, 1'b1, -1, 0, 0);
    run(0, 32'd7, -32'sd2, 1'b1, -1, 0, 0);
    run(0, 32'd12345, 32'd0, 1'b0, -1, 0, 0);
    run(0, -32'sd5, 32'd0, 1'b1, -1, 0, 0);
    run(0, 32'd1000, 32'd3, 1'b0, 10, 0, 0);
    run(0, 32'd1000, 32'd3, 1'b0, -1, 0, 0);
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 0, 0);
    run(0, 32'hFFFF_FFFF, 32'd1, 1'b0, -1, 0, 0);
    run(1, 32'h80, 32'hFF, 1'b1, -1, 0, 0);
    run(1, 32'hFF, 32'h01, 1'b0, -1, 0, 0);
    run(2, 32'h80, 32'hFF, 1'b1, -1, 0, 0);
    run(2, 32'd200, 32'd7, 1'b1, -1, 0, 0);
    run(0, 32'd999, 32'd4, 1'b0, 15, 1, 0);
    run(0, 32'd77, 32'd5, 1'b1, -1, 0, 1);
    run(0, 32'd81, 32'd9, 1'b0, -1, 0, 0);
    for (int i = 0; i < 80; i++) begin
      int k = $urandom_range(0, 2);
      int w = (k == 0) ? 32 : 8;
      logic [31:0] a = $urandom;
      logic [31:0] b;
      int sel = $urandom_range(0, 7);
      int c = -1;
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'd1 :
          (sel == 3) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if (sel == 4) a = (k == 0) ? 32'h8000_0000 : 32'h80;
      if ($urandom_range(0, 7) == 0 && ((k == 0) ? b : (b & 32'hFF)) != 0) c = $urandom_range(1, w);
      run(k, a, b, 1'($urandom), c, 1'($urandom), 1'($urandom_range(0, 5) == 0));
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("queue_empty dut%0d", k), 64'(exp_q[k].size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
